// File: rtl/ysyx_25070198_sbus_sram.sv
// SimpleBus word-wide SRAM responder with a fixed (or LFSR-randomised) response latency.
// Optional feature: define RANDOM_DELAY_EN to draw each request's delay from an 8-bit LFSR.
module ysyx_25070198_sbus_sram #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          DEPTH     = 4096,
  parameter int          LATENCY   = 2
`ifdef RANDOM_DELAY_EN
  , parameter logic [7:0] LFSR_SEED = 8'hA5
`endif
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] io_sram_addr,
  input  logic        io_sram_wen,
  input  logic [31:0] io_sram_wdata,
  input  logic [3:0]  io_sram_wmask,
  input  logic        io_sram_reqValid,
  output logic [31:0] io_sram_rdata,
  output logic        io_sram_respValid
);

  localparam int          AW   = $clog2(DEPTH);
  localparam int          CW   = (LATENCY > 8) ? $clog2(LATENCY + 1) : 4;
  localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t          r_state;
  logic [31:0]     r_addr;
  logic            r_wen;
  logic [31:0]     r_wdata;
  logic [3:0]      r_wmask;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_rdata;
  logic            r_resp_valid;
  logic [31:0]     r_mem [DEPTH];

  logic            w_accept;
  logic [31:0]     w_addr;
  logic            w_wen;
  logic [31:0]     w_wdata;
  logic [3:0]      w_wmask;
  logic [31:0]     w_offset;
  logic            w_in_range;
  logic [AW-1:0]   w_index;
  logic [CW-1:0]   w_delay;
  logic            w_enter_resp;
  logic            w_commit;
  logic [31:0]     w_rd_word;

  // In IDLE the live request is used directly so a D==1 request commits on its accept edge.
  assign w_accept = (r_state == S_IDLE) && io_sram_reqValid;
  assign w_addr   = (r_state == S_IDLE) ? io_sram_addr  : r_addr;
  assign w_wen    = (r_state == S_IDLE) ? io_sram_wen   : r_wen;
  assign w_wdata  = (r_state == S_IDLE) ? io_sram_wdata : r_wdata;
  assign w_wmask  = (r_state == S_IDLE) ? io_sram_wmask : r_wmask;

  // Below-base addresses wrap to a huge offset, so one compare covers both bounds.
  assign w_offset   = w_addr - BASE_ADDR;
  assign w_in_range = {1'b0, w_offset} < SPAN;
  assign w_index    = w_offset[AW+1:2];

`ifdef RANDOM_DELAY_EN
  logic [7:0] r_lfsr;
  assign w_delay = CW'(r_lfsr[2:0]) + CW'(1);
`else
  assign w_delay = CW'(LATENCY);
`endif

  assign w_enter_resp = (w_accept && (w_delay == CW'(1))) ||
                        ((r_state == S_BUSY) && (r_cnt == CW'(1)));
  assign w_commit     = w_enter_resp && w_wen && w_in_range && !reset;
  assign w_rd_word    = (!w_wen && w_in_range) ? r_mem[w_index] : 32'h0;

  // NOTE: the storage array has no reset branch; clearing thousands of words in one cycle
  // is not something a real SRAM does, and contents must survive a reset pulse.
  always_ff @(posedge clock) begin
    if (w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (w_wmask[i]) r_mem[w_index][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_wen        <= 1'b0;
      r_wdata      <= '0;
      r_wmask      <= '0;
      r_cnt        <= '0;
      r_rdata      <= '0;
      r_resp_valid <= 1'b0;
`ifdef RANDOM_DELAY_EN
      r_lfsr       <= LFSR_SEED;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_resp_valid <= 1'b0;
          r_rdata      <= '0;
          if (w_accept) begin
            r_addr  <= io_sram_addr;
            r_wen   <= io_sram_wen;
            r_wdata <= io_sram_wdata;
            r_wmask <= io_sram_wmask;
`ifdef RANDOM_DELAY_EN
            r_lfsr  <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
`endif
            if (w_delay == CW'(1)) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_rdata      <= w_rd_word;
            end else begin
              r_state <= S_BUSY;
              r_cnt   <= w_delay - CW'(1);
            end
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_rdata      <= w_rd_word;
          end
        end
        S_RESP: begin
          r_state      <= S_IDLE;
          r_resp_valid <= 1'b0;
          r_rdata      <= '0;
        end
        default: begin
          r_state      <= S_IDLE;
          r_resp_valid <= 1'b0;
          r_rdata      <= '0;
        end
      endcase
    end
  end

  assign io_sram_rdata     = r_rdata;
  assign io_sram_respValid = r_resp_valid;

endmodule
